// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic MAC array tile controller.
package systolic_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_FEED   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } ctrl_state_e;

    // Must stay equal to the depth of the array's reset synchroniser.
    localparam int SETTLE_CYCLES = 2;

    // Cycles of zero operands needed to push the last product out of the
    // skewed array pipeline.
    function automatic int DRAIN_CYCLES(input int rows, input int cols);
        return rows + cols + 32'sd2;
    endfunction

endpackage

// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for the INT8 systolic MAC array: clear, settle, feed K
// operand beats, drain with zero operands, then hold the result.
module systolic_tile_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS  = 32,
    parameter int COLS  = 16,
    parameter int K_MAX = 4096,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [KW-1:0] cmd_k,
    input  logic          op_valid,
    output logic          op_ready,
    output logic [KW-1:0] op_k,
    output logic          arr_clear,
    output logic          arr_en,
    output logic          arr_zero,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic [31:0]   stall_cnt
);

    // The settle and drain phases never overlap, so they share one counter.
    localparam int            CW          = $clog2(ROWS + COLS + 3);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYCLES(ROWS, COLS) - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [KW-1:0] K_MAX_V     = KW'(K_MAX);

    ctrl_state_e   state_r;
    logic [KW-1:0] k_len_r;
    logic [KW-1:0] op_k_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   stall_cnt_r;
    logic          cmd_ready_r;
    logic          busy_r;
    logic          op_ready_r;
    logic          arr_clear_r;
    logic          arr_en_r;
    logic          arr_zero_r;
    logic          res_valid_r;

    logic [KW-1:0] k_clamp_s;
    logic [KW-1:0] k_last_s;
    logic          stall_sat_s;

    // Clamp the requested reduction length and precompute the final beat index.
    always_comb begin
        k_clamp_s   = cmd_k;
        k_last_s    = k_len_r - KW'(1);
        stall_sat_s = &stall_cnt_r;
        if (cmd_k > K_MAX_V) begin
            k_clamp_s = K_MAX_V;
        end else begin
            k_clamp_s = cmd_k;
        end
    end

    // Sequencer: state, counters and registered control outputs together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            k_len_r     <= '0;
            op_k_r      <= '0;
            cnt_r       <= '0;
            stall_cnt_r <= 32'd0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            op_ready_r  <= 1'b0;
            arr_clear_r <= 1'b0;
            arr_en_r    <= 1'b0;
            arr_zero_r  <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        k_len_r     <= k_clamp_s;
                        op_k_r      <= '0;
                        stall_cnt_r <= 32'd0;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        arr_clear_r <= 1'b1;
                        state_r     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    arr_clear_r <= 1'b0;
                    cnt_r       <= SETTLE_LAST;
                    state_r     <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_r == '0) begin
                        if (k_len_r != '0) begin
                            op_ready_r <= 1'b1;
                            state_r    <= ST_FEED;
                        end else begin
                            cnt_r      <= DRAIN_LAST;
                            arr_en_r   <= 1'b1;
                            arr_zero_r <= 1'b1;
                            state_r    <= ST_DRAIN;
                        end
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_FEED: begin
                    if (op_valid) begin
                        if (op_k_r == k_last_s) begin
                            // Index stays on the final beat once feeding ends.
                            op_ready_r <= 1'b0;
                            cnt_r      <= DRAIN_LAST;
                            arr_en_r   <= 1'b1;
                            arr_zero_r <= 1'b1;
                            state_r    <= ST_DRAIN;
                        end else begin
                            op_k_r <= op_k_r + KW'(1);
                        end
                    end else if (!stall_sat_s) begin
                        stall_cnt_r <= stall_cnt_r + 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r == '0) begin
                        arr_en_r    <= 1'b0;
                        arr_zero_r  <= 1'b0;
                        res_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    op_ready_r  <= 1'b0;
                    arr_clear_r <= 1'b0;
                    arr_en_r    <= 1'b0;
                    arr_zero_r  <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign op_ready  = op_ready_r;
    assign op_k      = op_k_r;
    assign arr_clear = arr_clear_r;
    assign arr_zero  = arr_zero_r;
    assign res_valid = res_valid_r;
    assign stall_cnt = stall_cnt_r;
    // During FEED a missing beat freezes the whole array in the same cycle.
    assign arr_en    = op_ready_r ? op_valid : arr_en_r;

endmodule

// File: doc/systolic_tile_ctrl.md
# systolic_tile_ctrl

Sequencer for the rectangular INT8 systolic MAC array. It accepts one tile command holding a reduction length K. For each command it:
- clears the array through the array's synchronised reset path;
- streams K operand beats from the operand buffers under a valid/ready handshake;
- drains the pipeline with zero operands;
- holds the array frozen while the consumer reads `c_out`.

It sits between the tile scheduler (command side), the A/B operand buffers and the array itself.

## Interface
- `ROWS`, 32, array M dimension (used only to derive drain length)
- `COLS`, 16, array N dimension (used only to derive drain length)
- `K_MAX`, 4096, largest legal K
- `KW`, $clog2(K_MAX+1), width of K fields
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  tile command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_k`  in  KW  reduction length K, 0..K_MAX
- `op_valid`  in  1  A/B operand beat for index `op_k` present at buffer outputs
- `op_ready`  out  1  controller consumes beat this cycle
- `op_k`  out  KW  index of requested beat, 0..K-1
- `arr_clear`  out  1  drives the array's active-high `reset` input
- `arr_en`  out  1  drives the array's `enable` input
- `arr_zero`  out  1  forces array `a_in`/`b_in` muxes to 0 (drain)
- `res_valid`  out  1  array `c_out` holds the final tile result
- `res_ready`  in  1  consumer has read `c_out`
- `busy`  out  1  state != IDLE
- `stall_cnt`  out  32  FEED cycles with `op_valid`=0 in the current or last tile

## Operation
- States are IDLE, CLEAR, SETTLE, FEED, DRAIN and DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_k` into `k_len`, clear `stall_cnt`, go to CLEAR.
- **CLEAR**: `arr_clear`=1 for exactly 1 cycle, then go to SETTLE.
- **SETTLE**
  - Lasts exactly 2 cycles and covers the array's 2-stage reset synchroniser.
  - `arr_en`=0.
  - Go to FEED if `k_len`>0, otherwise go to DRAIN.
- **FEED**
  - `op_ready`=1 and `arr_en`=`op_valid`.
  - A beat transfers when `op_valid`&`op_ready`; each transfer increments `op_k`.
  - After the beat with `op_k`=`k_len`-1 transfers, go to DRAIN.
  - A cycle with `op_valid`=0 freezes the whole array (`arr_en`=0) and increments `stall_cnt`. The counter saturates at 2^32-1.
- **DRAIN**
  - `arr_en`=1 and `arr_zero`=1 for `DRAIN_CYCLES` = `ROWS`+`COLS`+2 cycles, then go to DONE.
  - No back-pressure is applied in DRAIN.
- **DONE**
  - `res_valid`=1 and `arr_en`=0, so `c_out` is stable.
  - On `res_ready`: go to IDLE.
- `op_k` resets to 0 on entry to CLEAR and holds its value outside FEED.
- `cmd_k` > `K_MAX` is clamped to `K_MAX`.
- Asynchronous reset at any point forces IDLE immediately. The in-flight tile is discarded; the next command's CLEAR wipes the array.

## Timing
- Output values while `reset_n`=0:
  - `cmd_ready`=1; `busy`=0.
  - `op_ready`, `arr_clear`, `arr_en`, `arr_zero`, `res_valid` are 0.
  - `op_k`=0 and `stall_cnt`=0.
- All handshake and array-control outputs are decoded from registered state/counters. There is no combinational path from `op_valid` to `op_ready` or from `res_ready` to `res_valid`.
- `arr_en` is the one exception: it is combinational from `op_valid` in FEED only.
- With the command accepted at cycle T and no stalls:
  - `arr_clear` is high in cycle T+1.
  - SETTLE occupies T+2..T+3.
  - FEED occupies T+4..T+3+K.
  - DRAIN occupies T+4+K..T+3+K+D.
  - `res_valid` rises at T+4+K+D, where D=`DRAIN_CYCLES`.
- Each stalled FEED cycle adds exactly 1 cycle to this latency.
- `res_valid` and `res_ready` high in the same cycle → IDLE in the next cycle, with `cmd_ready`=1 in that cycle.
- `cmd_valid` is ignored outside IDLE.
- Back-to-back tiles have a minimum gap of 1 IDLE cycle.

## Structure
- Shared package `systolic_pkg` holds:
  - `ctrl_state_e` (6-state enum);
  - the `DRAIN_CYCLES(rows, cols)` function;
  - the `SETTLE_CYCLES`=2 constant, which must stay equal to the array's reset synchroniser depth.
- No sub-module: the state register, the K counter, the drain/settle counter (shared, width $clog2(`ROWS`+`COLS`+3)) and the stall counter are all inline.

## Test plan
- K=16, `op_valid` held 1, `res_ready` held 1, defaults:
  - `arr_clear` is high at T+1;
  - `res_valid` is high at T+4+16+50 = T+70;
  - `stall_cnt`=0;
  - `op_k` sequence is 0..15.
- K=8 with `op_valid` low for 3 cycles after beat 4:
  - `arr_en`=0 in those cycles;
  - `res_valid` is delayed by exactly 3 cycles;
  - `stall_cnt`=3.
- K=0:
  - CLEAR→SETTLE→DRAIN→DONE;
  - `op_ready` is never asserted;
  - `res_valid` at T+4+50.
- `res_ready` held 0 for 10 cycles in DONE:
  - `res_valid` stays 1 and `arr_en` stays 0;
  - `cmd_valid` pulses are ignored;
  - on `res_ready`=1, IDLE follows 1 cycle later.
- `reset_n` asserted mid-FEED (beat 5 of 16):
  - all outputs take their reset values immediately;
  - a new K=4 command then completes normally and `stall_cnt`=0.
- `cmd_k`=`K_MAX`+5: `op_k` ends at `K_MAX`-1 (the clamp is applied).
